// File: rtl/processor_status_full.sv
// Processor status register: C/Z/I/D/V/N flags updated on the falling clock edge,
// plus a delayed copy of I used to gate IRQ recognition.
module processor_status_full #(
    parameter bit          DECIMAL_EN     = 1'b0,
    parameter bit          RESET_I        = 1'b1,
    parameter int unsigned IRQ_MASK_DELAY = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_db,
    input  logic       i_ir5,
    input  logic       i_acr,
    input  logic       i_avr,
    input  logic       i_db_p,
    input  logic       i_db0_c,
    input  logic       i_ir5_c,
    input  logic       i_acr_c,
    input  logic       i_db1_z,
    input  logic       i_dbz_z,
    input  logic       i_db2_i,
    input  logic       i_ir5_i,
    input  logic       i_set_i,
    input  logic       i_db3_d,
    input  logic       i_ir5_d,
    input  logic       i_avr_v,
    input  logic       i_db6_v,
    input  logic       i_1_v,
    input  logic       i_0_v,
    input  logic       i_db7_n,
    input  logic       i_break,
    output logic [7:0] o_p,
    output logic       o_irq_mask,
    output logic       o_decimal
);

    logic c_q, c_d;
    logic z_q, z_d;
    logic i_q, i_d;
    logic d_q, d_d;
    logic v_q, v_d;
    logic n_q, n_d;

    // Each if-chain encodes one flag's load-source priority, highest first.
    always_comb begin
        c_d = c_q;
        if (i_acr_c)                 c_d = i_acr;
        else if (i_db0_c || i_db_p)  c_d = i_db[0];
        else if (i_ir5_c)            c_d = i_ir5;

        z_d = z_q;
        if (i_dbz_z)                 z_d = (i_db == 8'h00);
        else if (i_db1_z || i_db_p)  z_d = i_db[1];

        i_d = i_q;
        if (i_set_i)                 i_d = 1'b1;
        else if (i_db2_i || i_db_p)  i_d = i_db[2];
        else if (i_ir5_i)            i_d = i_ir5;

        d_d = d_q;
        if (i_db3_d || i_db_p)       d_d = i_db[3];
        else if (i_ir5_d)            d_d = i_ir5;

        v_d = v_q;
        if (i_1_v)                   v_d = 1'b1;
        else if (i_avr_v)            v_d = i_avr;
        else if (i_db6_v || i_db_p)  v_d = i_db[6];
        else if (i_0_v)              v_d = 1'b0;

        n_d = n_q;
        if (i_db7_n || i_db_p)       n_d = i_db[7];
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            i_q <= RESET_I;
            d_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            i_q <= i_d;
            d_q <= d_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    // Plain shift register: every intermediate I value walks through each stage.
    generate
        if (IRQ_MASK_DELAY == 0) begin : g_no_delay
            assign o_irq_mask = i_q;
        end else begin : g_delay
            logic [IRQ_MASK_DELAY-1:0] mask_q, mask_d;

            always_comb begin
                mask_d    = mask_q;
                mask_d[0] = i_q;
                for (int unsigned k = 1; k < IRQ_MASK_DELAY; k++) begin
                    mask_d[k] = mask_q[k-1];
                end
            end

            always_ff @(negedge i_clk or posedge i_reset) begin
                if (i_reset) mask_q <= {IRQ_MASK_DELAY{RESET_I}};
                else         mask_q <= mask_d;
            end

            assign o_irq_mask = mask_q[IRQ_MASK_DELAY-1];
        end
    endgenerate

    assign o_p       = {n_q, v_q, 1'b1, i_break, d_q, i_q, z_q, c_q};
    assign o_decimal = DECIMAL_EN ? d_q : 1'b0;

endmodule

// File: tb/tb_processor_status_full.sv
// Scoreboard bench: four parameter variants share one stimulus stream; expected
// values are queued by the stimulus and popped by an independent monitor.
module tb_processor_status_full;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_db;
    logic       i_ir5, i_acr, i_avr, i_db_p;
    logic       i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z;
    logic       i_db2_i, i_ir5_i, i_set_i, i_db3_d, i_ir5_d;
    logic       i_avr_v, i_db6_v, i_1_v, i_0_v, i_db7_n, i_break;

    logic [7:0] p_act    [4];
    logic       mask_act [4];
    logic       dec_act  [4];

    always #5 i_clk = ~i_clk;

    // 0: defaults, 1: IRQ_MASK_DELAY=0, 2: IRQ_MASK_DELAY=3, 3: DECIMAL_EN=1
    processor_status_full u_def (
        .i_clk(i_clk), .i_reset(i_reset), .i_db(i_db), .i_ir5(i_ir5), .i_acr(i_acr),
        .i_avr(i_avr), .i_db_p(i_db_p), .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c),
        .i_acr_c(i_acr_c), .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z), .i_db2_i(i_db2_i),
        .i_ir5_i(i_ir5_i), .i_set_i(i_set_i), .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
        .i_avr_v(i_avr_v), .i_db6_v(i_db6_v), .i_1_v(i_1_v), .i_0_v(i_0_v),
        .i_db7_n(i_db7_n), .i_break(i_break),
        .o_p(p_act[0]), .o_irq_mask(mask_act[0]), .o_decimal(dec_act[0]));

    processor_status_full #(.IRQ_MASK_DELAY(0)) u_d0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_db(i_db), .i_ir5(i_ir5), .i_acr(i_acr),
        .i_avr(i_avr), .i_db_p(i_db_p), .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c),
        .i_acr_c(i_acr_c), .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z), .i_db2_i(i_db2_i),
        .i_ir5_i(i_ir5_i), .i_set_i(i_set_i), .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
        .i_avr_v(i_avr_v), .i_db6_v(i_db6_v), .i_1_v(i_1_v), .i_0_v(i_0_v),
        .i_db7_n(i_db7_n), .i_break(i_break),
        .o_p(p_act[1]), .o_irq_mask(mask_act[1]), .o_decimal(dec_act[1]));

    processor_status_full #(.IRQ_MASK_DELAY(3)) u_d3 (
        .i_clk(i_clk), .i_reset(i_reset), .i_db(i_db), .i_ir5(i_ir5), .i_acr(i_acr),
        .i_avr(i_avr), .i_db_p(i_db_p), .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c),
        .i_acr_c(i_acr_c), .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z), .i_db2_i(i_db2_i),
        .i_ir5_i(i_ir5_i), .i_set_i(i_set_i), .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
        .i_avr_v(i_avr_v), .i_db6_v(i_db6_v), .i_1_v(i_1_v), .i_0_v(i_0_v),
        .i_db7_n(i_db7_n), .i_break(i_break),
        .o_p(p_act[2]), .o_irq_mask(mask_act[2]), .o_decimal(dec_act[2]));

    processor_status_full #(.DECIMAL_EN(1'b1)) u_dec (
        .i_clk(i_clk), .i_reset(i_reset), .i_db(i_db), .i_ir5(i_ir5), .i_acr(i_acr),
        .i_avr(i_avr), .i_db_p(i_db_p), .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c),
        .i_acr_c(i_acr_c), .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z), .i_db2_i(i_db2_i),
        .i_ir5_i(i_ir5_i), .i_set_i(i_set_i), .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
        .i_avr_v(i_avr_v), .i_db6_v(i_db6_v), .i_1_v(i_1_v), .i_0_v(i_0_v),
        .i_db7_n(i_db7_n), .i_break(i_break),
        .o_p(p_act[3]), .o_irq_mask(mask_act[3]), .o_decimal(dec_act[3]));

    typedef struct {
        string      name;
        int         dut;
        int         field;   // 0: o_p, 1: o_irq_mask, 2: o_decimal
        logic [7:0] value;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void push_exp(string name, int dut, int field, logic [7:0] value);
        exp_t e;
        e.name = name; e.dut = dut; e.field = field; e.value = value;
        sb.push_back(e);
    endfunction

    // Push a full-output expectation for one DUT variant.
    function automatic void push_all(string name, int dut, logic [7:0] p, logic m, logic d);
        push_exp({name, ".p"},    dut, 0, p);
        push_exp({name, ".mask"}, dut, 1, {7'd0, m});
        push_exp({name, ".dec"},  dut, 2, {7'd0, d});
    endfunction

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.field)
                    0:       act = p_act[e.dut];
                    1:       act = {7'd0, mask_act[e.dut]};
                    default: act = {7'd0, dec_act[e.dut]};
                endcase
                n_total++;
                if (act === e.value) n_pass++;
                else $display("FAIL %s dut%0d: got %02h expected %02h", e.name, e.dut, act, e.value);
            end
        end
    end

    task automatic clear_inputs();
        i_db = 8'h00; i_ir5 = 0; i_acr = 0; i_avr = 0; i_db_p = 0;
        i_db0_c = 0; i_ir5_c = 0; i_acr_c = 0; i_db1_z = 0; i_dbz_z = 0;
        i_db2_i = 0; i_ir5_i = 0; i_set_i = 0; i_db3_d = 0; i_ir5_d = 0;
        i_avr_v = 0; i_db6_v = 0; i_1_v = 0; i_0_v = 0; i_db7_n = 0;
    endtask

    // Drive a fresh vector one time unit after the rising edge.
    task automatic start_cycle();
        @(posedge i_clk);
        #1;
        clear_inputs();
    endtask

    task automatic finish_cycle();
        @(negedge i_clk);
        #1;
    endtask

    task automatic check_now();
        -> chk_ev;
        #0;
    endtask

    initial begin
        clear_inputs();
        i_break = 0;
        i_reset = 1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 0;
        for (int k = 0; k < 4; k++) push_all("reset", k, 8'h24, 1'b1, 1'b0);
        check_now();

        // E1: PLP-style load of C3 with break high; I falls here
        start_cycle(); i_db = 8'hC3; i_db_p = 1; i_break = 1; finish_cycle();
        push_all("plp_c3", 0, 8'hF3, 1'b1, 1'b0);
        push_exp("plp_c3.mask", 1, 1, 8'h00);
        push_exp("plp_c3.mask", 2, 1, 8'h01);
        check_now();

        // E2: Z from zero-detect on 00
        start_cycle(); i_db = 8'h00; i_dbz_z = 1; finish_cycle();
        push_all("dbz_zero", 0, 8'hF3, 1'b0, 1'b0);
        push_exp("dbz_zero.mask", 2, 1, 8'h01);
        check_now();

        // E3: zero-detect beats i_db1_z with i_db[1]=1
        start_cycle(); i_db = 8'h02; i_dbz_z = 1; i_db1_z = 1; finish_cycle();
        push_exp("dbz_nonzero.p", 0, 0, 8'hF1);
        push_exp("lag3_e2.mask", 2, 1, 8'h01);
        check_now();

        // E4: CLV
        start_cycle(); i_0_v = 1; finish_cycle();
        push_exp("clv.p", 0, 0, 8'hB1);
        push_exp("lag3_e3.mask", 2, 1, 8'h00);
        check_now();

        // E5: C priority acr over db0, V priority set over avr, same edge
        start_cycle();
        i_acr_c = 1; i_acr = 0; i_db0_c = 1; i_db = 8'h01;
        i_1_v = 1; i_avr_v = 1; i_avr = 0;
        finish_cycle();
        push_exp("c_v_prio.p", 0, 0, 8'hF0);
        check_now();

        // E6: SED
        start_cycle(); i_ir5_d = 1; i_ir5 = 1; finish_cycle();
        push_all("sed_def", 0, 8'hF8, 1'b0, 1'b0);
        push_all("sed_dec", 3, 8'hF8, 1'b0, 1'b1);
        check_now();

        // E7: set_i beats db2_i; SEC via ir5_c
        start_cycle(); i_set_i = 1; i_db2_i = 1; i_db = 8'h00; i_ir5_c = 1; i_ir5 = 1; finish_cycle();
        push_all("seti_sec", 0, 8'hFD, 1'b0, 1'b0);
        push_exp("seti.mask", 1, 1, 8'h01);
        check_now();

        // E8: hold, break low
        start_cycle(); i_break = 0; finish_cycle();
        push_all("hold", 0, 8'hED, 1'b1, 1'b0);
        check_now();

        // E9: CLI; I was 1 for only two edges
        start_cycle(); i_ir5_i = 1; i_ir5 = 0; finish_cycle();
        push_all("cli", 0, 8'hE9, 1'b1, 1'b0);
        push_exp("cli.mask", 1, 1, 8'h00);
        push_exp("pulse_e9.mask", 2, 1, 8'h00);
        check_now();

        start_cycle(); finish_cycle();
        push_exp("cli_lag1.mask", 0, 1, 8'h00);
        push_exp("pulse_e10.mask", 2, 1, 8'h01);
        check_now();

        // E11: N from i_db[7]=0
        start_cycle(); i_db7_n = 1; i_db = 8'h00; finish_cycle();
        push_exp("ldn.p", 0, 0, 8'h69);
        push_exp("pulse_e11.mask", 2, 1, 8'h01);
        check_now();

        start_cycle(); finish_cycle();
        push_exp("pulse_e12.mask", 2, 1, 8'h00);
        check_now();

        // Reset asserted between edges while a full load is pending
        start_cycle(); i_db = 8'hFF; i_db_p = 1;
        #2 i_reset = 1;
        #1;
        for (int k = 0; k < 4; k++) push_all("async_rst", k, 8'h24, 1'b1, 1'b0);
        check_now();
        finish_cycle();
        for (int k = 0; k < 4; k++) push_all("rst_held", k, 8'h24, 1'b1, 1'b0);
        check_now();

        start_cycle(); i_reset = 0; finish_cycle();
        push_all("post_rst", 0, 8'h24, 1'b1, 1'b0);
        check_now();

        start_cycle(); i_db = 8'hFF; i_db_p = 1; finish_cycle();
        push_all("load_ff", 0, 8'hEF, 1'b1, 1'b0);
        push_all("load_ff", 3, 8'hEF, 1'b1, 1'b1);
        check_now();

        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
